odd_operand_fetch: RTL and testbench
====================================

// Module: odd_operand_fetch
// PURPOSE
// - RF/FWD issue stage feeding the odd pipe. It is the consumer side of the odd pipe's forwarding and hazard interface.
// - Latches one decoded instruction and stalls it while any source register matches an in-flight odd-pipe result not yet forwardable.
// - Resolves each operand from fw stages 1..6, then the WB stage, then the register file, and issues to the pipe with registered outputs.
// PARAMETERS
// - DATA_W     128  operand width
// - ADDR_W     7    register address width
// - LS_DEPTH   6    ls1 pending-result entries
// - P1_DEPTH   4    p1 pending-result entries
// - CNT_W      16   stall counter width
// PORTS
// clk              in   1          clock
// reset            in   1          synchronous, active-high
// in_valid         in   1          decoded instr available
// in_ready         out  1          instr accepted this cycle when in_valid&in_ready
// in_op/in_format  in   11/3       opcode, format
// in_unit          in   2          0 Perm, 1 LS, 2 Br, 3 undefined
// in_rt_addr       in   ADDR_W     destination register
// in_reg_write     in   1          instr writes RF
// in_imm           in   18         immediate
// in_pc            in   8          PC of instr
// in_first         in   1          first in pair
// in_ra/rb/rc_addr in   ADDR_W x3  source addrs; rc = store/rt source
// in_ra/rb/rc_used in   1 x3       source actually read
// rf_ra/rb/rc_addr out  ADDR_W x3  RF read addrs; combinational from hold reg
// rf_ra/rb/rc_data in   DATA_W x3  RF read data, same cycle
// fw_wb            in   7xDATA_W   odd-pipe forward stages; index 0 unused
// fw_addr_wb       in   7xADDR_W   stage destinations
// fw_write_wb      in   7          stage valid-write
// rt_wb/rt_addr_wb/reg_write_wb in DATA_W/ADDR_W/1  WB stage
// rt_addr_delay_ls1/reg_write_delay_ls1 in LS_DEPTH x ADDR_W / LS_DEPTH  ls1 pending
// rt_addr_delay_p1/reg_write_delay_p1   in P1_DEPTH x ADDR_W / P1_DEPTH  p1 pending
// branch_kill      in   1          flush held and issuing instr
// ex_valid         out  1          issue pulse to odd pipe
// ex_op/format/unit/rt_addr/reg_write/imm/pc/first out  registered copy of held instr
// ex_ra/ex_rb/ex_rt_st out DATA_W x3  resolved operands
// stall_cnt        out  CNT_W      saturating count of stall cycles
// BEHAVIOUR
// - Reset: state IDLE. All ex_* = 0, stall_cnt = 0, hold register cleared. in_ready = 1 from the first post-reset cycle.
// - State IDLE (hold empty). in_ready = 1. Accept -> HOLD.
// - State HOLD. hazard = OR over used sources s of (addr_s == rt_addr_delay_ls1[i] & reg_write_delay_ls1[i]) or the same test against the p1 list.
// - No register address is exempt from the hazard check.
// - HOLD & !hazard: issue. Next edge ex_valid = 1 with operands resolved this cycle.
// - On issue, in_ready = 1: a same-cycle accept stays in HOLD, otherwise go to IDLE. Throughput is 1 instr/clk with no hazards.
// - HOLD & hazard: in_ready = 0, ex_valid = 0 next edge, stall_cnt +1 (saturates at all-ones).
// - Latency: accept at edge N; with no hazard, ex_valid at edge N+1.
// - Operand priority per source, youngest first: fw[1] > fw[2] > ... > fw[6] > WB > RF.
// - A stage matches only when its fw_write_wb bit is 1 and its address is equal; fw[0] is ignored.
// - Unused source: operand = 0.
// - ex_rt_st resolves from rc.
// - branch_kill wins over everything:
//   - hold cleared, state IDLE, ex_valid = 0 next edge.
//   - in_ready = 0 that cycle, so nothing is accepted.
//   - an instr issuing in the kill cycle is suppressed.
// - reset mid-stall: same as reset; the held instr is lost.
// - ex_* other than ex_valid hold their last values when ex_valid = 0.
// STRUCTURE
// - Shared package spu_pkg:
//   - unit_e {UNIT_PERM, UNIT_LS, UNIT_BR, UNIT_UNDEF}
//   - fw_stage_t {data, addr, write}
//   - constants NUM_FW = 7, DATA_W, ADDR_W
// - Sub-module fwd_select (combinational priority mux: addr, used, fw array, WB, RF data -> operand), instanced 3x.
// - Top holds the FSM, hold register, hazard compare and output regs.
// TESTING
// - No hazard: ra = r5, RF r5 = 0xA..A, fw empty -> ex_valid at N+1, ex_ra = 0xA..A, stall_cnt = 0.
// - Forward priority: r9 in fw[2] = 0x22, fw[5] = 0x55, WB = 0x77 -> ex_ra = 0x22.
//   Remove fw[2] -> 0x55.
//   Remove fw[5] -> 0x77.
// - ls1 hazard: r12 in reg_write_delay_ls1[3], drained after 3 clk -> in_ready low 3 clk, ex_valid at N+4, stall_cnt = 3.
//   The same entry with its write bit 0 -> no stall.
// - Back-to-back: 4 independent instrs with in_valid held -> 4 consecutive ex_valid pulses, in_ready constantly 1.
// - Kill: branch_kill during a p1 stall on r3 -> no ex_valid for that instr; next instr accepted cycle after.
//   Kill in an issue cycle -> that ex_valid is suppressed.
// - Reset: assert reset mid-HOLD -> ex_valid = 0, in_ready = 1, stall_cnt = 0 next cycle.
//   Saturation: CNT_W = 2 forced stall of 5 clk -> stall_cnt = 3.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared odd-pipe types: unit encoding, forward-stage record and pipe-wide widths.
package spu_pkg;

    localparam int unsigned NUM_FW = 7;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 7;

    typedef enum logic [1:0] {
        UNIT_PERM  = 2'd0,
        UNIT_LS    = 2'd1,
        UNIT_BR    = 2'd2,
        UNIT_UNDEF = 2'd3
    } unit_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              write;
    } fw_stage_t;

endpackage

// File: rtl/odd_operand_fetch_if.sv
// Decode-to-issue handshake and issue-to-odd-pipe bundle of the operand fetch stage.
interface odd_operand_fetch_if #(
    parameter int unsigned DATA_W = spu_pkg::DATA_W,
    parameter int unsigned ADDR_W = spu_pkg::ADDR_W
);
    import spu_pkg::unit_e;

    logic              in_valid;
    logic              in_ready;
    logic [10:0]       in_op;
    logic [2:0]        in_format;
    unit_e             in_unit;
    logic [ADDR_W-1:0] in_rt_addr;
    logic              in_reg_write;
    logic [17:0]       in_imm;
    logic [7:0]        in_pc;
    logic              in_first;
    logic [ADDR_W-1:0] in_ra_addr;
    logic [ADDR_W-1:0] in_rb_addr;
    logic [ADDR_W-1:0] in_rc_addr;
    logic              in_ra_used;
    logic              in_rb_used;
    logic              in_rc_used;

    logic              ex_valid;
    logic [10:0]       ex_op;
    logic [2:0]        ex_format;
    unit_e             ex_unit;
    logic [ADDR_W-1:0] ex_rt_addr;
    logic              ex_reg_write;
    logic [17:0]       ex_imm;
    logic [7:0]        ex_pc;
    logic              ex_first;
    logic [DATA_W-1:0] ex_ra;
    logic [DATA_W-1:0] ex_rb;
    logic [DATA_W-1:0] ex_rt_st;

    modport slave (
        input  in_valid, in_op, in_format, in_unit, in_rt_addr, in_reg_write, in_imm, in_pc,
               in_first, in_ra_addr, in_rb_addr, in_rc_addr, in_ra_used, in_rb_used, in_rc_used,
        output in_ready,
        output ex_valid, ex_op, ex_format, ex_unit, ex_rt_addr, ex_reg_write, ex_imm, ex_pc,
               ex_first, ex_ra, ex_rb, ex_rt_st
    );

    modport master (
        output in_valid, in_op, in_format, in_unit, in_rt_addr, in_reg_write, in_imm, in_pc,
               in_first, in_ra_addr, in_rb_addr, in_rc_addr, in_ra_used, in_rb_used, in_rc_used,
        input  in_ready,
        input  ex_valid, ex_op, ex_format, ex_unit, ex_rt_addr, ex_reg_write, ex_imm, ex_pc,
               ex_first, ex_ra, ex_rb, ex_rt_st
    );

endinterface

// File: rtl/odd_operand_fetch_fwd_select.sv
// Per-source operand mux: youngest forward stage first, then WB, then register file.
module fwd_select
    import spu_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic              used,
    input  fw_stage_t         fw [NUM_FW],
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_write,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (wb_write && (wb_addr == addr))
            operand = wb_data;
        // Walk oldest stage to youngest so a younger match overrides; stage 0 never forwards.
        for (int unsigned k = 0; k < NUM_FW; k++) begin
            if (((NUM_FW - 1 - k) != 0) && fw[NUM_FW-1-k].write && (fw[NUM_FW-1-k].addr == addr))
                operand = fw[NUM_FW-1-k].data;
        end
        if (!used)
            operand = '0;
    end

endmodule

// File: rtl/odd_operand_fetch.sv
// Odd-pipe RF/FWD issue stage: holds one instr, stalls on pending writers, issues resolved operands.
module odd_operand_fetch
    import spu_pkg::NUM_FW;
    import spu_pkg::fw_stage_t;
    import spu_pkg::unit_e;
    import spu_pkg::UNIT_PERM;
#(
    parameter int unsigned DATA_W   = spu_pkg::DATA_W,
    parameter int unsigned ADDR_W   = spu_pkg::ADDR_W,
    parameter int unsigned LS_DEPTH = 6,
    parameter int unsigned P1_DEPTH = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    odd_operand_fetch_if.slave  bus,
    output logic [ADDR_W-1:0]   rf_ra_addr,
    output logic [ADDR_W-1:0]   rf_rb_addr,
    output logic [ADDR_W-1:0]   rf_rc_addr,
    input  logic [DATA_W-1:0]   rf_ra_data,
    input  logic [DATA_W-1:0]   rf_rb_data,
    input  logic [DATA_W-1:0]   rf_rc_data,
    input  logic [DATA_W-1:0]   fw_wb [NUM_FW],
    input  logic [ADDR_W-1:0]   fw_addr_wb [NUM_FW],
    input  logic [NUM_FW-1:0]   fw_write_wb,
    input  logic [DATA_W-1:0]   rt_wb,
    input  logic [ADDR_W-1:0]   rt_addr_wb,
    input  logic                reg_write_wb,
    input  logic [ADDR_W-1:0]   rt_addr_delay_ls1 [LS_DEPTH],
    input  logic [LS_DEPTH-1:0] reg_write_delay_ls1,
    input  logic [ADDR_W-1:0]   rt_addr_delay_p1 [P1_DEPTH],
    input  logic [P1_DEPTH-1:0] reg_write_delay_p1,
    input  logic                branch_kill,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e            state, state_next;
    logic [10:0]       h_op;
    logic [2:0]        h_format;
    unit_e             h_unit;
    logic [ADDR_W-1:0] h_rt_addr, h_ra_addr, h_rb_addr, h_rc_addr;
    logic              h_reg_write, h_first, h_ra_used, h_rb_used, h_rc_used;
    logic [17:0]       h_imm;
    logic [7:0]        h_pc;

    logic              hazard, ready, issue, stall, accept;
    fw_stage_t         fw [NUM_FW];
    logic [DATA_W-1:0] ra_val, rb_val, rc_val;

    assign rf_ra_addr   = h_ra_addr;
    assign rf_rb_addr   = h_rb_addr;
    assign rf_rc_addr   = h_rc_addr;
    assign bus.in_ready = ready;

    always_comb begin
        for (int unsigned i = 0; i < NUM_FW; i++) begin
            fw[i].data  = fw_wb[i];
            fw[i].addr  = fw_addr_wb[i];
            fw[i].write = fw_write_wb[i];
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < LS_DEPTH; i++) begin
            if (reg_write_delay_ls1[i] &&
                ((h_ra_used && (h_ra_addr == rt_addr_delay_ls1[i])) ||
                 (h_rb_used && (h_rb_addr == rt_addr_delay_ls1[i])) ||
                 (h_rc_used && (h_rc_addr == rt_addr_delay_ls1[i]))))
                hazard = 1'b1;
        end
        for (int unsigned i = 0; i < P1_DEPTH; i++) begin
            if (reg_write_delay_p1[i] &&
                ((h_ra_used && (h_ra_addr == rt_addr_delay_p1[i])) ||
                 (h_rb_used && (h_rb_addr == rt_addr_delay_p1[i])) ||
                 (h_rc_used && (h_rc_addr == rt_addr_delay_p1[i]))))
                hazard = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        issue      = 1'b0;
        stall      = 1'b0;
        unique case (state)
            IDLE: ready = 1'b1;
            HOLD: begin
                if (hazard) begin
                    stall = 1'b1;
                end else begin
                    issue = 1'b1;
                    ready = 1'b1;
                end
            end
        endcase
        if (branch_kill) begin
            ready = 1'b0;
            issue = 1'b0;
            stall = 1'b0;
        end
        accept = bus.in_valid && ready;
        if (branch_kill)
            state_next = IDLE;
        else if (accept)
            state_next = HOLD;
        else if (issue)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset || branch_kill) begin
            h_op <= '0; h_format <= '0; h_unit <= UNIT_PERM; h_rt_addr <= '0;
            h_reg_write <= 1'b0; h_imm <= '0; h_pc <= '0; h_first <= 1'b0;
            h_ra_addr <= '0; h_rb_addr <= '0; h_rc_addr <= '0;
            h_ra_used <= 1'b0; h_rb_used <= 1'b0; h_rc_used <= 1'b0;
        end else if (accept) begin
            h_op <= bus.in_op; h_format <= bus.in_format; h_unit <= bus.in_unit;
            h_rt_addr <= bus.in_rt_addr; h_reg_write <= bus.in_reg_write;
            h_imm <= bus.in_imm; h_pc <= bus.in_pc; h_first <= bus.in_first;
            h_ra_addr <= bus.in_ra_addr; h_rb_addr <= bus.in_rb_addr; h_rc_addr <= bus.in_rc_addr;
            h_ra_used <= bus.in_ra_used; h_rb_used <= bus.in_rb_used; h_rc_used <= bus.in_rc_used;
        end
    end

    fwd_select u_sel_ra (.addr(h_ra_addr), .used(h_ra_used), .fw(fw), .wb_data(rt_wb),
                         .wb_addr(rt_addr_wb), .wb_write(reg_write_wb), .rf_data(rf_ra_data), .operand(ra_val));
    fwd_select u_sel_rb (.addr(h_rb_addr), .used(h_rb_used), .fw(fw), .wb_data(rt_wb),
                         .wb_addr(rt_addr_wb), .wb_write(reg_write_wb), .rf_data(rf_rb_data), .operand(rb_val));
    fwd_select u_sel_rc (.addr(h_rc_addr), .used(h_rc_used), .fw(fw), .wb_data(rt_wb),
                         .wb_addr(rt_addr_wb), .wb_write(reg_write_wb), .rf_data(rf_rc_data), .operand(rc_val));

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ex_valid <= 1'b0; bus.ex_op <= '0; bus.ex_format <= '0; bus.ex_unit <= UNIT_PERM;
            bus.ex_rt_addr <= '0; bus.ex_reg_write <= 1'b0; bus.ex_imm <= '0; bus.ex_pc <= '0;
            bus.ex_first <= 1'b0; bus.ex_ra <= '0; bus.ex_rb <= '0; bus.ex_rt_st <= '0;
        end else begin
            bus.ex_valid <= issue;
            if (issue) begin
                bus.ex_op <= h_op; bus.ex_format <= h_format; bus.ex_unit <= h_unit;
                bus.ex_rt_addr <= h_rt_addr; bus.ex_reg_write <= h_reg_write;
                bus.ex_imm <= h_imm; bus.ex_pc <= h_pc; bus.ex_first <= h_first;
                bus.ex_ra <= ra_val; bus.ex_rb <= rb_val; bus.ex_rt_st <= rc_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_odd_operand_fetch.sv
// Scoreboard bench for odd_operand_fetch: issue timing, forwarding priority, stalls, kill and reset.
module tb_odd_operand_fetch;
    import spu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    odd_operand_fetch_if bus ();
    odd_operand_fetch_if bus2 ();

    logic [ADDR_W-1:0] rf_ra_addr, rf_rb_addr, rf_rc_addr, rf2_ra_addr, rf2_rb_addr, rf2_rc_addr;
    logic [DATA_W-1:0] rf_ra_data, rf_rb_data, rf_rc_data, rf2_ra_data, rf2_rb_data, rf2_rc_data;
    logic [DATA_W-1:0] fw_wb [NUM_FW];
    logic [ADDR_W-1:0] fw_addr_wb [NUM_FW];
    logic [NUM_FW-1:0] fw_write_wb;
    logic [DATA_W-1:0] rt_wb;
    logic [ADDR_W-1:0] rt_addr_wb;
    logic              reg_write_wb;
    logic [ADDR_W-1:0] rt_addr_delay_ls1 [6];
    logic [5:0]        reg_write_delay_ls1;
    logic [ADDR_W-1:0] rt_addr_delay_p1 [4];
    logic [3:0]        reg_write_delay_p1;
    logic              branch_kill;
    logic [15:0]       stall_cnt;
    logic [1:0]        stall_cnt_sat;

    logic [DATA_W-1:0] rf_mem [128];

    typedef struct {
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;
        logic [DATA_W-1:0] rt;
        logic [7:0]        pc;
    } exp_t;
    exp_t sb [$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    assign rf_ra_data  = rf_mem[rf_ra_addr];
    assign rf_rb_data  = rf_mem[rf_rb_addr];
    assign rf_rc_data  = rf_mem[rf_rc_addr];
    assign rf2_ra_data = rf_mem[rf2_ra_addr];
    assign rf2_rb_data = rf_mem[rf2_rb_addr];
    assign rf2_rc_data = rf_mem[rf2_rc_addr];

    // The narrow-counter instance sees exactly the same instruction stream.
    assign bus2.in_valid = bus.in_valid;     assign bus2.in_op = bus.in_op;
    assign bus2.in_format = bus.in_format;   assign bus2.in_unit = bus.in_unit;
    assign bus2.in_rt_addr = bus.in_rt_addr; assign bus2.in_reg_write = bus.in_reg_write;
    assign bus2.in_imm = bus.in_imm;         assign bus2.in_pc = bus.in_pc;
    assign bus2.in_first = bus.in_first;     assign bus2.in_ra_addr = bus.in_ra_addr;
    assign bus2.in_rb_addr = bus.in_rb_addr; assign bus2.in_rc_addr = bus.in_rc_addr;
    assign bus2.in_ra_used = bus.in_ra_used; assign bus2.in_rb_used = bus.in_rb_used;
    assign bus2.in_rc_used = bus.in_rc_used;

    odd_operand_fetch #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_rc_addr(rf_rc_addr),
        .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
        .fw_wb(fw_wb), .fw_addr_wb(fw_addr_wb), .fw_write_wb(fw_write_wb),
        .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
        .rt_addr_delay_ls1(rt_addr_delay_ls1), .reg_write_delay_ls1(reg_write_delay_ls1),
        .rt_addr_delay_p1(rt_addr_delay_p1), .reg_write_delay_p1(reg_write_delay_p1),
        .branch_kill(branch_kill), .stall_cnt(stall_cnt)
    );

    odd_operand_fetch #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2),
        .rf_ra_addr(rf2_ra_addr), .rf_rb_addr(rf2_rb_addr), .rf_rc_addr(rf2_rc_addr),
        .rf_ra_data(rf2_ra_data), .rf_rb_data(rf2_rb_data), .rf_rc_data(rf2_rc_data),
        .fw_wb(fw_wb), .fw_addr_wb(fw_addr_wb), .fw_write_wb(fw_write_wb),
        .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
        .rt_addr_delay_ls1(rt_addr_delay_ls1), .reg_write_delay_ls1(reg_write_delay_ls1),
        .rt_addr_delay_p1(rt_addr_delay_p1), .reg_write_delay_p1(reg_write_delay_p1),
        .branch_kill(branch_kill), .stall_cnt(stall_cnt_sat)
    );

    task automatic clear_side();
        for (int i = 0; i < NUM_FW; i++) begin
            fw_wb[i] = '0;
            fw_addr_wb[i] = '0;
        end
        fw_write_wb = '0;
        rt_wb = '0; rt_addr_wb = '0; reg_write_wb = 1'b0;
        for (int i = 0; i < 6; i++) rt_addr_delay_ls1[i] = '0;
        for (int i = 0; i < 4; i++) rt_addr_delay_p1[i] = '0;
        reg_write_delay_ls1 = '0;
        reg_write_delay_p1  = '0;
        branch_kill = 1'b0;
    endtask

    task automatic send(input logic [7:0] pc, input logic [6:0] ra, input logic [6:0] rb,
                        input logic [6:0] rc, input logic [2:0] used);
        bus.in_valid = 1'b1; bus.in_op = {3'b000, pc}; bus.in_format = pc[2:0];
        bus.in_unit = UNIT_LS; bus.in_rt_addr = pc[6:0]; bus.in_reg_write = 1'b1;
        bus.in_imm = {10'h000, pc}; bus.in_pc = pc; bus.in_first = pc[0];
        bus.in_ra_addr = ra; bus.in_rb_addr = rb; bus.in_rc_addr = rc;
        bus.in_ra_used = used[0]; bus.in_rb_used = used[1]; bus.in_rc_used = used[2];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b want 0", bus.ex_valid); end
        checks++; if (bus.ex_ra !== '0) begin errors++; $display("FAIL reset_ex_ra: got %h want 0", bus.ex_ra); end
        checks++; if (bus.ex_pc !== 8'h00) begin errors++; $display("FAIL reset_ex_pc: got %h want 0", bus.ex_pc); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        reset = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_no_hazard();
        @(negedge clk);
        send(8'h01, 7'd5, 7'd6, 7'd7, 3'b001);
        sb.push_back('{ra: {32{4'hA}}, rb: '0, rt: '0, pc: 8'h01});
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL nohaz_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL nohaz_early: ex_valid got %b want 0", bus.ex_valid); end
        @(negedge clk);
        checks++;
        if (bus.ex_valid !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL nohaz_issue: ex_valid got %b queued %0d want 1", bus.ex_valid, sb.size());
        end else begin
            e = sb.pop_front();
            checks++; if (bus.ex_ra !== e.ra) begin errors++; $display("FAIL nohaz_ra: got %h want %h", bus.ex_ra, e.ra); end
            checks++; if (bus.ex_rb !== e.rb) begin errors++; $display("FAIL nohaz_rb_unused: got %h want %h", bus.ex_rb, e.rb); end
            checks++; if (bus.ex_pc !== e.pc || bus.ex_op !== {3'b000, e.pc} || bus.ex_unit !== UNIT_LS || bus.ex_imm !== {10'h000, e.pc})
                begin errors++; $display("FAIL nohaz_fields: pc %h op %h imm %h want pc %h", bus.ex_pc, bus.ex_op, bus.ex_imm, e.pc); end
        end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL nohaz_stall: got %0d want 0", stall_cnt); end
        @(negedge clk);
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL nohaz_single: ex_valid got %b want 0", bus.ex_valid); end
    endtask

    task automatic test_fwd_priority();
        logic [DATA_W-1:0] want [4];
        want[0] = 128'h22; want[1] = 128'h55; want[2] = 128'h77; want[3] = rf_mem[9];
        fw_addr_wb[0] = 7'd9; fw_wb[0] = 128'hDEAD; fw_write_wb[0] = 1'b1;
        fw_addr_wb[1] = 7'd10; fw_wb[1] = 128'h11; fw_write_wb[1] = 1'b1;
        fw_addr_wb[3] = 7'd9;  fw_wb[3] = 128'h33; fw_write_wb[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            fw_addr_wb[2] = 7'd9; fw_wb[2] = 128'h22; fw_write_wb[2] = (k < 1);
            fw_addr_wb[5] = 7'd9; fw_wb[5] = 128'h55; fw_write_wb[5] = (k < 2);
            rt_addr_wb = 7'd9; rt_wb = 128'h77; reg_write_wb = (k < 3);
            send(8'h10 + 8'(k), 7'd9, 7'd9, 7'd9, 3'b111);
            sb.push_back('{ra: want[k], rb: want[k], rt: want[k], pc: 8'h10 + 8'(k)});
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.ex_valid !== 1'b1 || sb.size() == 0) begin
                errors++; $display("FAIL fwd_issue_%0d: ex_valid got %b want 1", k, bus.ex_valid);
            end else begin
                e = sb.pop_front();
                checks++; if (bus.ex_ra !== e.ra || bus.ex_rb !== e.rb || bus.ex_rt_st !== e.rt)
                    begin errors++; $display("FAIL fwd_prio_%0d: ra %h rb %h rt %h want %h", k, bus.ex_ra, bus.ex_rb, bus.ex_rt_st, e.ra); end
            end
        end
        clear_side();
    endtask

    task automatic test_ls1_hazard();
        @(negedge clk);
        rt_addr_delay_ls1[3] = 7'd12; reg_write_delay_ls1[3] = 1'b1;
        send(8'h20, 7'd1, 7'd12, 7'd2, 3'b010);
        sb.push_back('{ra: '0, rb: rf_mem[12], rt: '0, pc: 8'h20});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++; if (bus.in_ready !== 1'b0 || bus.ex_valid !== 1'b0)
                begin errors++; $display("FAIL ls1_stall_%0d: in_ready %b ex_valid %b want 0 0", k, bus.in_ready, bus.ex_valid); end
        end
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL ls1_stall_cnt: got %0d want 3", stall_cnt); end
        reg_write_delay_ls1[3] = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ls1_drained_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        checks++;
        if (bus.ex_valid !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL ls1_issue: ex_valid got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front();
            checks++; if (bus.ex_rb !== e.rb || bus.ex_pc !== e.pc) begin errors++; $display("FAIL ls1_data: rb %h pc %h want %h %h", bus.ex_rb, bus.ex_pc, e.rb, e.pc); end
        end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL ls1_stall_final: got %0d want 3", stall_cnt); end
        // Same pending address with its write bit low must not stall.
        send(8'h21, 7'd1, 7'd12, 7'd2, 3'b010);
        sb.push_back('{ra: '0, rb: rf_mem[12], rt: '0, pc: 8'h21});
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ls1_nowrite_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        checks++;
        if (bus.ex_valid !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL ls1_nowrite_issue: ex_valid got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front();
            checks++; if (bus.ex_pc !== e.pc) begin errors++; $display("FAIL ls1_nowrite_pc: got %h want %h", bus.ex_pc, e.pc); end
        end
        clear_side();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2 && i <= 5) begin
                checks++;
                if (bus.ex_valid !== 1'b1 || sb.size() == 0) begin
                    errors++; $display("FAIL b2b_issue_%0d: ex_valid got %b want 1", i - 2, bus.ex_valid);
                end else begin
                    e = sb.pop_front();
                    checks++; if (bus.ex_ra !== e.ra || bus.ex_pc !== e.pc)
                        begin errors++; $display("FAIL b2b_data_%0d: ra %h pc %h want %h %h", i - 2, bus.ex_ra, bus.ex_pc, e.ra, e.pc); end
                end
            end
            if (i == 6) begin
                checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: ex_valid got %b want 0", bus.ex_valid); end
            end
            if (i < 4) begin
                send(8'h30 + 8'(i), 7'(20 + i), 7'd0, 7'd0, 3'b001);
                sb.push_back('{ra: rf_mem[20 + i], rb: '0, rt: '0, pc: 8'h30 + 8'(i)});
                #1;
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 1", i, bus.in_ready); end
            end else begin
                bus.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_kill();
        @(negedge clk);
        rt_addr_delay_p1[2] = 7'd3; reg_write_delay_p1[2] = 1'b1;
        send(8'h40, 7'd3, 7'd0, 7'd0, 3'b001);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL kill_p1_stall: in_ready got %b want 0", bus.in_ready); end
        @(negedge clk);
        branch_kill = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL kill_ready: got %b want 0", bus.in_ready); end
        @(negedge clk);
        branch_kill = 1'b0; reg_write_delay_p1[2] = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL kill_no_issue: ex_valid got %b want 0", bus.ex_valid); end
        send(8'h41, 7'd5, 7'd0, 7'd0, 3'b001);
        sb.push_back('{ra: rf_mem[5], rb: '0, rt: '0, pc: 8'h41});
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL kill_next_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL kill_ghost: ex_valid got %b want 0", bus.ex_valid); end
        @(negedge clk);
        checks++;
        if (bus.ex_valid !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL kill_next_issue: ex_valid got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front();
            checks++; if (bus.ex_pc !== e.pc || bus.ex_ra !== e.ra) begin errors++; $display("FAIL kill_next_data: pc %h ra %h want %h %h", bus.ex_pc, bus.ex_ra, e.pc, e.ra); end
        end
        // Kill landing on the issue cycle, with a new instr offered at the same time.
        send(8'h50, 7'd6, 7'd0, 7'd0, 3'b001);
        @(negedge clk);
        send(8'h51, 7'd7, 7'd0, 7'd0, 3'b001);
        branch_kill = 1'b1;
        @(negedge clk);
        branch_kill = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL kill_issue_cycle: ex_valid got %b want 0", bus.ex_valid); end
        checks++; if (bus.ex_pc !== 8'h41) begin errors++; $display("FAIL kill_hold_pc: got %h want 41", bus.ex_pc); end
        @(negedge clk);
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL kill_no_accept: ex_valid got %b want 0", bus.ex_valid); end
        clear_side();
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        rt_addr_delay_p1[0] = 7'd3; reg_write_delay_p1[0] = 1'b1;
        send(8'h60, 7'd3, 7'd0, 7'd0, 3'b001);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        reg_write_delay_p1[0] = 1'b0;
        #1;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 8'h00) begin errors++; $display("FAIL rst_mid_ex: valid %b pc %h want 0 00", bus.ex_valid, bus.ex_pc); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", bus.in_ready); end
        checks++; if (stall_cnt !== 16'd0 || stall_cnt_sat !== 2'd0) begin errors++; $display("FAIL rst_mid_stall: got %0d/%0d want 0/0", stall_cnt, stall_cnt_sat); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_lost: ex_valid got %b want 0", bus.ex_valid); end
        end
        clear_side();
    endtask

    task automatic test_saturation();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rt_addr_delay_ls1[0] = 7'd4; reg_write_delay_ls1[0] = 1'b1;
        send(8'h70, 7'd4, 7'd0, 7'd0, 3'b001);
        sb.push_back('{ra: rf_mem[4], rb: '0, rt: '0, pc: 8'h70});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        checks++; if (stall_cnt !== 16'd4 || stall_cnt_sat !== 2'd3) begin errors++; $display("FAIL sat_cnt4: got %0d/%0d want 4/3", stall_cnt, stall_cnt_sat); end
        @(negedge clk);
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d want 5", stall_cnt); end
        checks++; if (stall_cnt_sat !== 2'd3) begin errors++; $display("FAIL sat_narrow: got %0d want 3", stall_cnt_sat); end
        reg_write_delay_ls1[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ex_valid !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL sat_issue: ex_valid got %b want 1", bus.ex_valid);
        end else begin
            e = sb.pop_front();
            checks++; if (bus.ex_ra !== e.ra) begin errors++; $display("FAIL sat_data: ra %h want %h", bus.ex_ra, e.ra); end
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
        clear_side();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rf_mem[i] = {4{32'h1000_0000 + 32'(i)}};
        rf_mem[5] = {32{4'hA}};
        clear_side();
        bus.in_valid = 1'b0;
        send(8'h00, 7'd0, 7'd0, 7'd0, 3'b000);
        bus.in_valid = 1'b0;
        test_reset();
        test_no_hazard();
        test_fwd_priority();
        test_ls1_hazard();
        test_back_to_back();
        test_kill();
        test_reset_mid_hold();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
